// File: rtl/game_ctrl_fsm.sv
// Two-player round controller for the factorization game: button edge
// conditioning, timed result screens and HP bookkeeping around one state register.
module game_ctrl_fsm #(
   parameter int SHOW_CYC = 50000000,
   parameter int HP_W     = 2,
   parameter int HP_INIT  = 3,
   parameter int SEL_W    = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [SEL_W-1:0] SEL_IN,
   input  logic             DEC_IN,
   input  logic             CLR_IN,
   input  logic             QUE_IN,
   input  logic             OK_IN,
   input  logic             QUE,
   input  logic [1:0]       JUDG_IN,
   input  logic             WRONG_IN,
   output logic             READY,
   output logic [3:0]       STATE,
   output logic [SEL_W-1:0] SEL_OUT,
   output logic             DEC_OUT,
   output logic             CLR_OUT,
   output logic [HP_W-1:0]  HP_ME,
   output logic [HP_W-1:0]  HP_OPP
);

   localparam logic [3:0] ST_READY    = 4'b0010;
   localparam logic [3:0] ST_QUESTION = 4'b0011;
   localparam logic [3:0] ST_INPUT    = 4'b0100;
   localparam logic [3:0] ST_DRAW     = 4'b0110;
   localparam logic [3:0] ST_WRONG    = 4'b0111;
   localparam logic [3:0] ST_GOOD     = 4'b1000;
   localparam logic [3:0] ST_OUCH     = 4'b1001;
   localparam logic [3:0] ST_WIN      = 4'b1010;
   localparam logic [3:0] ST_LOSE     = 4'b1011;

   localparam int               TMR_W    = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SHOW_CYC - 1);
   localparam logic [HP_W-1:0]  HP_LOAD  = HP_W'(HP_INIT);

   logic [3:0]       r_state;
   logic [SEL_W-1:0] r_selNow, r_selPrev;
   logic             r_decNow, r_decPrev;
   logic             r_clrNow, r_clrPrev;
   logic             r_queNow, r_quePrev;
   logic [SEL_W-1:0] r_selOut;
   logic             r_decOut, r_clrOut;
   logic [HP_W-1:0]  r_hpMe, r_hpOpp;
   logic [TMR_W-1:0] r_timer;

   logic [SEL_W-1:0] w_selRise;
   logic             w_decRise, w_clrRise, w_queRise;
   logic             w_expired, w_meZero, w_oppZero;
   logic             w_enter, w_reload;
   logic [3:0]       w_next;

   function automatic logic isResult(input logic [3:0] s);
      return (s == ST_WRONG) || (s == ST_GOOD) || (s == ST_OUCH) ||
             (s == ST_DRAW)  || (s == ST_WIN)  || (s == ST_LOSE);
   endfunction

   assign w_selRise = r_selNow & ~r_selPrev;
   assign w_decRise = r_decNow & ~r_decPrev;
   assign w_clrRise = r_clrNow & ~r_clrPrev;
   assign w_queRise = r_queNow & ~r_quePrev;
   assign w_expired = (r_timer == '0);
   assign w_meZero  = (r_hpMe == '0);
   assign w_oppZero = (r_hpOpp == '0);
   assign w_enter   = (w_next != r_state);
   // A finished game, or a draw that knocked both players out, starts over at full HP.
   assign w_reload  = w_expired && ((r_state == ST_WIN) || (r_state == ST_LOSE) ||
                      ((r_state == ST_DRAW) && w_meZero && w_oppZero));

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_selNow  <= '0;
         r_selPrev <= '0;
         r_decNow  <= 1'b0;
         r_decPrev <= 1'b0;
         r_clrNow  <= 1'b0;
         r_clrPrev <= 1'b0;
         r_queNow  <= 1'b0;
         r_quePrev <= 1'b0;
      end else begin
         r_selNow  <= SEL_IN;
         r_selPrev <= r_selNow;
         r_decNow  <= DEC_IN;
         r_decPrev <= r_decNow;
         r_clrNow  <= CLR_IN;
         r_clrPrev <= r_clrNow;
         r_queNow  <= QUE_IN;
         r_quePrev <= r_queNow;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_READY: begin
            if (OK_IN && QUE) w_next = ST_QUESTION;
         end
         ST_QUESTION: begin
            if (!QUE)           w_next = ST_READY;
            else if (w_queRise) w_next = ST_INPUT;
         end
         ST_INPUT: begin
            // Judge results outrank our own WRONG flag raised in the same cycle.
            if (!QUE)                  w_next = ST_READY;
            else if (JUDG_IN == 2'b01) w_next = ST_GOOD;
            else if (JUDG_IN == 2'b10) w_next = ST_OUCH;
            else if (JUDG_IN == 2'b11) w_next = ST_DRAW;
            else if (WRONG_IN)         w_next = ST_WRONG;
            else if (w_queRise)        w_next = ST_QUESTION;
         end
         ST_WRONG: begin
            if (w_expired) w_next = ST_INPUT;
         end
         ST_GOOD: begin
            if (w_expired) w_next = w_oppZero ? ST_WIN : ST_READY;
         end
         ST_OUCH: begin
            if (w_expired) w_next = w_meZero ? ST_LOSE : ST_READY;
         end
         ST_DRAW: begin
            if (w_expired) begin
               if (w_oppZero && !w_meZero)      w_next = ST_WIN;
               else if (w_meZero && !w_oppZero) w_next = ST_LOSE;
               else                             w_next = ST_READY;
            end
         end
         ST_WIN, ST_LOSE: begin
            if (w_expired) w_next = ST_READY;
         end
         default: w_next = ST_READY;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_READY;
         r_timer <= '0;
         r_hpMe  <= HP_LOAD;
         r_hpOpp <= HP_LOAD;
      end else begin
         r_state <= w_next;
         if (w_enter && isResult(w_next)) r_timer <= TMR_LOAD;
         else if (!w_expired)             r_timer <= r_timer - 1'b1;
         if (w_reload) begin
            r_hpMe  <= HP_LOAD;
            r_hpOpp <= HP_LOAD;
         end else if (w_enter) begin
            case (w_next)
               ST_GOOD: if (!w_oppZero) r_hpOpp <= r_hpOpp - 1'b1;
               ST_OUCH: if (!w_meZero)  r_hpMe  <= r_hpMe - 1'b1;
               ST_DRAW: begin
                  if (!w_oppZero) r_hpOpp <= r_hpOpp - 1'b1;
                  if (!w_meZero)  r_hpMe  <= r_hpMe - 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_selOut <= '0;
         r_decOut <= 1'b0;
         r_clrOut <= 1'b0;
      end else begin
         if (w_enter && (w_next == ST_READY)) r_selOut <= '0;
         else if (r_state == ST_INPUT)        r_selOut <= r_selOut ^ w_selRise;
         r_decOut <= (r_state == ST_INPUT) && w_decRise;
         r_clrOut <= (r_state == ST_INPUT) && w_clrRise;
      end
   end

   assign READY   = (r_state == ST_READY);
   assign STATE   = r_state;
   assign SEL_OUT = r_selOut;
   assign DEC_OUT = r_decOut;
   assign CLR_OUT = r_clrOut;
   assign HP_ME   = r_hpMe;
   assign HP_OPP  = r_hpOpp;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Randomized bench for game_ctrl_fsm: a round-level game model predicts the
// sequence of screens and HP values; a monitor checks every state change.
module tb_game_ctrl_fsm;

   localparam int SHOW_CYC = 4;
   localparam int HP_W     = 2;
   localparam int HP_INIT  = 3;
   localparam int SEL_W    = 3;

   localparam logic [3:0] S_READY    = 4'b0010;
   localparam logic [3:0] S_QUESTION = 4'b0011;
   localparam logic [3:0] S_INPUT    = 4'b0100;
   localparam logic [3:0] S_DRAW     = 4'b0110;
   localparam logic [3:0] S_WRONG    = 4'b0111;
   localparam logic [3:0] S_GOOD     = 4'b1000;
   localparam logic [3:0] S_OUCH     = 4'b1001;
   localparam logic [3:0] S_WIN      = 4'b1010;
   localparam logic [3:0] S_LOSE     = 4'b1011;

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic [SEL_W-1:0] SEL_IN = '0;
   logic             DEC_IN = 1'b0, CLR_IN = 1'b0, QUE_IN = 1'b0;
   logic             OK_IN = 1'b0, QUE = 1'b0, WRONG_IN = 1'b0;
   logic [1:0]       JUDG_IN = 2'b00;
   logic             READY, DEC_OUT, CLR_OUT;
   logic [3:0]       STATE;
   logic [SEL_W-1:0] SEL_OUT;
   logic [HP_W-1:0]  HP_ME, HP_OPP;

   game_ctrl_fsm #(.SHOW_CYC(SHOW_CYC), .HP_W(HP_W), .HP_INIT(HP_INIT), .SEL_W(SEL_W)) dut (
      .CLK(CLK), .RST(RST), .SEL_IN(SEL_IN), .DEC_IN(DEC_IN), .CLR_IN(CLR_IN),
      .QUE_IN(QUE_IN), .OK_IN(OK_IN), .QUE(QUE), .JUDG_IN(JUDG_IN), .WRONG_IN(WRONG_IN),
      .READY(READY), .STATE(STATE), .SEL_OUT(SEL_OUT), .DEC_OUT(DEC_OUT),
      .CLR_OUT(CLR_OUT), .HP_ME(HP_ME), .HP_OPP(HP_OPP)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] st;
      int         me;
      int         opp;
      int         sel;
   } exp_t;

   exp_t expQ[$];
   int   nTests = 0, nFail = 0;
   int   mMe = HP_INIT, mOpp = HP_INIT, mSel = 0;
   int   expDec = 0, expClr = 0, decSeen = 0, clrSeen = 0;
   bit   monEn = 1'b0;

   function automatic bit isRes(input logic [3:0] s);
      return (s == S_WRONG) || (s == S_GOOD) || (s == S_OUCH) ||
             (s == S_DRAW) || (s == S_WIN) || (s == S_LOSE);
   endfunction

   function automatic int satDec(input int v);
      return (v > 0) ? v - 1 : 0;
   endfunction

   task automatic checkOutput(input string name, input int act, input int req);
      nTests++;
      if (act != req) begin
         nFail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pushExp(input logic [3:0] s);
      expQ.push_back('{st: s, me: mMe, opp: mOpp, sel: mSel});
   endtask

   task automatic goReady();
      mSel = 0;
      pushExp(S_READY);
   endtask

   task automatic finishGame(input logic [3:0] s);
      pushExp(s);
      mMe  = HP_INIT;
      mOpp = HP_INIT;
      goReady();
   endtask

   // Monitor: every screen change is matched against the next predicted screen.
   initial begin
      logic [3:0] prevState;
      int         dwell;
      logic       prevDec, prevClr;
      exp_t       e;
      prevState = S_READY;
      dwell = 1;
      prevDec = 1'b0;
      prevClr = 1'b0;
      forever begin
         @(negedge CLK);
         if (!monEn) begin
            prevState = STATE;
            dwell = 1;
         end else if (STATE != prevState) begin
            if (isRes(prevState)) checkOutput("result screen dwell", dwell, SHOW_CYC);
            if (expQ.size() == 0) begin
               nTests++;
               nFail++;
               $display("[TB] FAIL unexpected state: got %b, expected no change from %b", STATE, prevState);
            end else begin
               e = expQ.pop_front();
               checkOutput("STATE", STATE, e.st);
               checkOutput("HP_ME", HP_ME, e.me);
               checkOutput("HP_OPP", HP_OPP, e.opp);
               checkOutput("SEL_OUT", SEL_OUT, e.sel);
               checkOutput("READY", READY, (e.st == S_READY) ? 1 : 0);
            end
            prevState = STATE;
            dwell = 1;
         end else begin
            dwell++;
         end
         if (DEC_OUT) begin
            decSeen++;
            checkOutput("DEC_OUT pulse width", prevDec, 0);
         end
         if (CLR_OUT) begin
            clrSeen++;
            checkOutput("CLR_OUT pulse width", prevClr, 0);
         end
         prevDec = DEC_OUT;
         prevClr = CLR_OUT;
      end
   end

   task automatic resync();
      monEn = 1'b0;
      RST = 1'b1;
      SEL_IN = '0; DEC_IN = 0; CLR_IN = 0; QUE_IN = 0;
      OK_IN = 0; QUE = 0; JUDG_IN = 0; WRONG_IN = 0;
      tick();
      tick();
      RST = 1'b0;
      expQ.delete();
      mMe = HP_INIT;
      mOpp = HP_INIT;
      mSel = 0;
      tick();
      tick();
      expDec = decSeen;
      expClr = clrSeen;
      monEn = 1'b1;
   endtask

   task automatic waitDrain(input bit junk);
      int n = 0;
      while (expQ.size() != 0 && n < 60) begin
         tick();
         n++;
         if (junk) begin
            JUDG_IN  = 2'($urandom);
            WRONG_IN = 1'($urandom);
         end
      end
      JUDG_IN  = 2'b00;
      WRONG_IN = 1'b0;
      if (expQ.size() != 0) begin
         nTests++;
         nFail++;
         $display("[TB] FAIL timeout: got %0d screens outstanding, expected 0", expQ.size());
         resync();
      end
   endtask

   task automatic actReady();
      QUE = 1'b1;
      OK_IN = 1'b1;
      JUDG_IN = 2'($urandom);
      pushExp(S_QUESTION);
      tick();
      OK_IN = 1'b0;
      JUDG_IN = 2'b00;
      waitDrain(1'b0);
   endtask

   task automatic actIdleReady();
      QUE = 1'b0;
      OK_IN = 1'b1;
      repeat (2) tick();
      OK_IN = 1'b0;
      checkOutput("READY holds without QUE", STATE, S_READY);
   endtask

   task automatic actButtons(input bit inInput);
      int mask, d, c, hold;
      mask = $urandom_range(0, 7);
      d = $urandom_range(0, 1);
      c = $urandom_range(0, 1);
      if (mask == 0 && d == 0 && c == 0) d = 1;
      hold = $urandom_range(1, 5);
      SEL_IN = SEL_W'(mask);
      DEC_IN = 1'(d);
      CLR_IN = 1'(c);
      if (!inInput) begin
         JUDG_IN  = 2'($urandom);
         WRONG_IN = 1'($urandom);
      end
      repeat (hold) tick();
      SEL_IN = '0; DEC_IN = 0; CLR_IN = 0; JUDG_IN = 0; WRONG_IN = 0;
      repeat (4) tick();
      if (inInput) begin
         mSel ^= mask;
         expDec += d;
         expClr += c;
      end
      checkOutput("SEL_OUT after press", SEL_OUT, mSel);
   endtask

   task automatic actQueRise(input logic [3:0] target);
      int h = $urandom_range(1, 10);
      pushExp(target);
      JUDG_IN = 2'b00;
      QUE_IN = 1'b1;
      repeat (h) tick();
      QUE_IN = 1'b0;
      waitDrain(1'b0);
      repeat (2) tick();
   endtask

   task automatic actDropQue(input bit inInput);
      QUE = 1'b0;
      if (inInput) begin
         JUDG_IN  = 2'($urandom);
         WRONG_IN = 1'($urandom);
      end
      goReady();
      tick();
      JUDG_IN = 2'b00;
      WRONG_IN = 1'b0;
      waitDrain(1'b0);
   endtask

   task automatic actWrong();
      WRONG_IN = 1'b1;
      pushExp(S_WRONG);
      pushExp(S_INPUT);
      tick();
      WRONG_IN = 1'b0;
      waitDrain(1'b0);
   endtask

   task automatic actJudge();
      int j = $urandom_range(1, 3);
      JUDG_IN = 2'(j);
      WRONG_IN = 1'($urandom);
      if (j == 1) begin
         mOpp = satDec(mOpp);
         pushExp(S_GOOD);
         if (mOpp == 0) finishGame(S_WIN);
         else goReady();
      end else if (j == 2) begin
         mMe = satDec(mMe);
         pushExp(S_OUCH);
         if (mMe == 0) finishGame(S_LOSE);
         else goReady();
      end else begin
         mMe = satDec(mMe);
         mOpp = satDec(mOpp);
         pushExp(S_DRAW);
         if (mOpp == 0 && mMe != 0) finishGame(S_WIN);
         else if (mMe == 0 && mOpp != 0) finishGame(S_LOSE);
         else begin
            if (mMe == 0 && mOpp == 0) begin
               mMe = HP_INIT;
               mOpp = HP_INIT;
            end
            goReady();
         end
      end
      tick();
      waitDrain(1'b1);
   endtask

   // One round-level action chosen according to the screen the model is on.
   task automatic applyStimulus();
      int r = $urandom_range(0, 99);
      if (STATE == S_READY) begin
         if (r < 80) actReady();
         else actIdleReady();
      end else if (STATE == S_QUESTION) begin
         if (r < 20) actDropQue(1'b0);
         else if (r < 40) actButtons(1'b0);
         else actQueRise(S_INPUT);
      end else if (STATE == S_INPUT) begin
         if (r < 10) actDropQue(1'b1);
         else if (r < 20) actQueRise(S_QUESTION);
         else if (r < 45) actButtons(1'b1);
         else if (r < 60) actWrong();
         else actJudge();
      end else begin
         nTests++;
         nFail++;
         $display("[TB] FAIL idle state: got %b, expected READY/QUESTION/INPUT", STATE);
         resync();
      end
   endtask

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      RST = 1'b1;
      tick();
      tick();
      checkOutput("reset STATE", STATE, S_READY);
      checkOutput("reset READY", READY, 1);
      checkOutput("reset HP_ME", HP_ME, HP_INIT);
      checkOutput("reset HP_OPP", HP_OPP, HP_INIT);
      checkOutput("reset SEL_OUT", SEL_OUT, 0);
      checkOutput("reset DEC_OUT", DEC_OUT, 0);
      checkOutput("reset CLR_OUT", CLR_OUT, 0);
      RST = 1'b0;
      tick();
      monEn = 1'b1;

      for (int i = 0; i < 500; i++) applyStimulus();
      repeat (4) tick();
      checkOutput("DEC_OUT pulse count", decSeen, expDec);
      checkOutput("CLR_OUT pulse count", clrSeen, expClr);

      // Reset landing in the second cycle of a GOOD screen.
      resync();
      actReady();
      actQueRise(S_INPUT);
      JUDG_IN = 2'b01;
      mOpp = satDec(mOpp);
      pushExp(S_GOOD);
      tick();
      JUDG_IN = 2'b00;
      tick();
      checkOutput("GOOD observed before reset", expQ.size(), 0);
      monEn = 1'b0;
      RST = 1'b1;
      tick();
      checkOutput("mid-GOOD reset STATE", STATE, S_READY);
      checkOutput("mid-GOOD reset HP_ME", HP_ME, HP_INIT);
      checkOutput("mid-GOOD reset HP_OPP", HP_OPP, HP_INIT);
      checkOutput("mid-GOOD reset DEC_OUT", DEC_OUT, 0);
      checkOutput("mid-GOOD reset CLR_OUT", CLR_OUT, 0);
      RST = 1'b0;
      QUE = 1'b0;
      repeat (SHOW_CYC + 2) tick();
      checkOutput("post-reset STATE held", STATE, S_READY);
      checkOutput("post-reset HP_OPP held", HP_OPP, HP_INIT);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/game_ctrl_fsm.md
Name: game_ctrl_fsm

Overview:
- Parametrised two-player round controller for the factorization game. It is the successor to the fixed top-level CONTROL sequencer.
- Adds real display timers in place of the fixed "1 second" waits, internal HP bookkeeping, rising-edge button conditioning, and priority-resolved result handling.
- Sits between the button/READY/judge modules and the display, which decodes STATE.

Parameters:
- SHOW_CYC, 50000000, cycles each result screen (WRONG/GOOD/OUCH/DRAW/WIN/LOSE) is held; must be >=1.
- HP_W, 2, width of each HP counter.
- HP_INIT, 3, HP loaded at reset and at every new game; range 1..2^HP_W-1.
- SEL_W, 3, number of digit-select buttons/toggles.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; one clock; reset is synchronous and active-high.
- SEL_IN  in  SEL_W  raw digit-select buttons, level.
- DEC_IN  in  1  raw decide button.
- CLR_IN  in  1  raw clear button.
- QUE_IN  in  1  raw question/input view-switch button.
- OK_IN  in  1  both players pressed start (from READY module).
- QUE  in  1  question loaded in input module.
- JUDG_IN  in  2  01 = we answered first, 10 = opponent first, 11 = simultaneous, 00 = none.
- WRONG_IN  in  1  our answer incorrect, one-cycle pulse.
- READY  out  1  high while STATE==READY.
- STATE  out  4  current state code.
- SEL_OUT  out  SEL_W  per-bit toggle of SEL_IN.
- DEC_OUT  out  1  one-cycle decide pulse.
- CLR_OUT  out  1  one-cycle clear pulse.
- HP_ME  out  HP_W  own HP.
- HP_OPP  out  HP_W  opponent HP.

Behaviour:
State codes:
- READY=0010, QUESTION=0011, INPUT=0100, DRAW=0110, WRONG=0111, GOOD=1000, OUCH=1001, WIN=1010, LOSE=1011.

Reset:
- Synchronous; dominates everything, including mid-round and mid-timer.
- On reset: STATE=READY, SEL_OUT=0, DEC_OUT=0, CLR_OUT=0, HP_ME=HP_OPP=HP_INIT, timer=0, all edge-detect registers=0.

Input conditioning:
- Each raw button is registered once. A rise is detected as current high AND previous low.
- Holding a button produces exactly one event.

Outputs on button events:
- SEL_OUT[i] toggles on a SEL_IN[i] rise, only in INPUT. It clears to 0 on entry to READY.
- DEC_OUT and CLR_OUT pulse high for exactly one cycle, the cycle after the rise, only in INPUT.

Next-state rules (next-state is combinational; STATE updates on the following edge, i.e. one-cycle latency from a sampled condition):
- READY: OK_IN && QUE -> QUESTION.
- QUESTION:
  - !QUE -> READY.
  - QUE_IN rise -> INPUT.
- INPUT, priority high to low:
  1. !QUE -> READY.
  2. JUDG_IN==01 -> GOOD; 10 -> OUCH; 11 -> DRAW.
  3. WRONG_IN -> WRONG.
  4. QUE_IN rise -> QUESTION.
  - A judge result and WRONG_IN in the same cycle: the judge result wins.
- WRONG: on timer expiry -> INPUT.
- GOOD: on expiry -> WIN if HP_OPP==0, else READY.
- OUCH: on expiry -> LOSE if HP_ME==0, else READY.
- DRAW: on expiry:
  - HP_OPP==0 && HP_ME!=0 -> WIN.
  - HP_ME==0 && HP_OPP!=0 -> LOSE.
  - Otherwise -> READY; if both are 0, reload both HP to HP_INIT.
- WIN, LOSE: on expiry -> READY and reload both HP to HP_INIT.
- Judge inputs are ignored outside INPUT. Unused state codes -> READY.

HP:
- Updated on the cycle of entry, i.e. same edge as STATE changes.
- GOOD: HP_OPP-1. OUCH: HP_ME-1. DRAW: both -1.
- Saturating at 0; never wraps.

Timer:
- Down-counter, width clog2(SHOW_CYC).
- Loaded with SHOW_CYC-1 on entry to any result state. Decrements each cycle.
- Expiry is the cycle the counter reads 0, so the state is held exactly SHOW_CYC cycles.
- Re-entry (e.g. WIN reached from GOOD) reloads the counter.

Test Plan:
- Reset with SHOW_CYC=4, HP_INIT=3: STATE=0010, READY=1, HP_ME=HP_OPP=3, SEL_OUT=000. Then OK_IN=1, QUE=1 -> STATE=0011 next edge.
- In QUESTION, one QUE_IN rise held 10 cycles -> STATE=0100, stays 0100. Second rise -> 0011. Drop QUE -> 0010.
- In INPUT: SEL_IN=001 held 5 cycles -> SEL_OUT=001 (single toggle); DEC_IN rise -> DEC_OUT high exactly 1 cycle. WRONG_IN pulse -> STATE=0111 for 4 cycles, then 0100.
- In INPUT, JUDG_IN=01 and WRONG_IN=1 same cycle -> STATE=1000, HP_OPP=2, 4 cycles, then 0010. Repeat 3 times -> after third GOOD, STATE=1010 for 4 cycles, then 0010 with HP both 3.
- HP_ME=HP_OPP=1, JUDG_IN=11 -> DRAW, both HP 0, after 4 cycles STATE=0010 with HP reloaded to 3. Separately, HP_ME=1: JUDG_IN=10 -> OUCH then LOSE (1011).
- Assert RST in the 2nd cycle of GOOD -> next edge STATE=0010, timer 0, HP=3, DEC_OUT/CLR_OUT low.
